// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the fetch/decode front end: instruction encoding
// fields, opcode and register constants, and the IF/ID register layout.
package instruction_fetch_unit_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned IMEM_DEPTH_DEFAULT = 256;

    // A zero word with if_id_valid low is treated by decode as a bubble.
    localparam logic [31:0] NOP_INSTR = 32'd0;

    // Opcode field position inside an instruction word.
    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_ADDI = 6'd5,
        OP_BEQ  = 6'd6,
        OP_JMP  = 6'd7,
        OP_CALL = 6'd8,
        OP_RET  = 6'd9
    } opcode_e;

    // Architectural register constants.
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    // Which state update the fetch stage performs on the coming edge.
    typedef enum logic [1:0] {
        FETCH_RESET    = 2'd0,
        FETCH_REDIRECT = 2'd1,
        FETCH_HOLD     = 2'd2,
        FETCH_ADVANCE  = 2'd3
    } fetch_action_e;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic [31:0] pc_plus1;
        logic        valid;
        logic        fault;
    } if_id_t;

    // Extract the opcode field of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

    // Build an I-type style word: opcode, rd, rs, 16-bit immediate.
    function automatic logic [31:0] make_instr(input logic [5:0]  op,
                                               input logic [4:0]  rd,
                                               input logic [4:0]  rs,
                                               input logic [15:0] imm);
        return {op, rd, rs, imm};
    endfunction

    // True when a word address lies inside the populated instruction memory.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, tracks the word in flight through the
// one-cycle synchronous instruction memory, applies stalls and redirects,
// and loads the IF/ID register consumed by decode.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        if_id_fault
);

    localparam logic [31:0] LP_DEPTH = 32'(IMEM_DEPTH);

    // Architectural state.
    logic [31:0]   r_pc;
    logic [31:0]   r_fetch_pc;
    logic          r_fetch_valid;
    if_id_t        r_if_id;

    // Next-state values.
    fetch_action_e w_action;
    logic [31:0]   w_pc_next;
    logic [31:0]   w_fetch_pc_next;
    logic          w_fetch_valid_next;
    if_id_t        w_if_id_next;
    logic          w_fetch_in_range;
    if_id_t        w_if_id_reset;

    assign w_fetch_in_range = addr_in_range(r_fetch_pc, LP_DEPTH);

    assign w_if_id_reset = '{instruction: NOP_INSTR,
                             pc:          32'd0,
                             pc_plus1:    32'd0,
                             valid:       1'b0,
                             fault:       1'b0};

    // Select the update for this edge: reset > redirect > stall > advance.
    always_comb begin
        w_action = FETCH_ADVANCE;
        if (reset) begin
            w_action = FETCH_RESET;
        end else if (redirect_valid) begin
            w_action = FETCH_REDIRECT;
        end else if (stall) begin
            w_action = FETCH_HOLD;
        end else begin
            w_action = FETCH_ADVANCE;
        end
    end

    // Memory address; on a stall the in-flight word is re-read so the
    // memory output stays stable until decode accepts it.
    always_comb begin
        imem_address = r_pc;
        case (w_action)
            FETCH_RESET:    imem_address = RESET_PC;
            FETCH_REDIRECT: imem_address = redirect_target;
            FETCH_HOLD:     imem_address = r_fetch_pc;
            FETCH_ADVANCE:  imem_address = r_pc;
            default:        imem_address = r_pc;
        endcase
    end

    // Next PC, in-flight tracking and IF/ID contents for each update kind.
    always_comb begin
        w_pc_next          = r_pc;
        w_fetch_pc_next    = r_fetch_pc;
        w_fetch_valid_next = r_fetch_valid;
        w_if_id_next       = r_if_id;
        case (w_action)
            FETCH_RESET: begin
                w_pc_next          = RESET_PC;
                w_fetch_pc_next    = RESET_PC;
                w_fetch_valid_next = 1'b0;
                w_if_id_next       = w_if_id_reset;
            end
            FETCH_REDIRECT: begin
                // Flush IF/ID; pc fields hold so decode sees a stable bubble.
                w_pc_next                = redirect_target + 32'd1;
                w_fetch_pc_next          = redirect_target;
                w_fetch_valid_next       = 1'b1;
                w_if_id_next.instruction = NOP_INSTR;
                w_if_id_next.valid       = 1'b0;
                w_if_id_next.fault       = 1'b0;
            end
            FETCH_HOLD: begin
                w_pc_next          = r_pc;
                w_fetch_pc_next    = r_fetch_pc;
                w_fetch_valid_next = r_fetch_valid;
                w_if_id_next       = r_if_id;
            end
            FETCH_ADVANCE: begin
                // Out-of-range words still move down the pipe, marked faulted.
                w_pc_next                = r_pc + 32'd1;
                w_fetch_pc_next          = r_pc;
                w_fetch_valid_next       = 1'b1;
                w_if_id_next.instruction = imem_instruction;
                w_if_id_next.pc          = r_fetch_pc;
                w_if_id_next.pc_plus1    = r_fetch_pc + 32'd1;
                w_if_id_next.valid       = r_fetch_valid & w_fetch_in_range;
                w_if_id_next.fault       = r_fetch_valid & ~w_fetch_in_range;
            end
            default: begin
                w_pc_next          = r_pc;
                w_fetch_pc_next    = r_fetch_pc;
                w_fetch_valid_next = r_fetch_valid;
                w_if_id_next       = r_if_id;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_pc    <= RESET_PC;
            r_fetch_valid <= 1'b0;
            r_if_id       <= w_if_id_reset;
        end else begin
            r_pc          <= w_pc_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_fetch_valid <= w_fetch_valid_next;
            r_if_id       <= w_if_id_next;
        end
    end

    assign if_id_instruction = r_if_id.instruction;
    assign if_id_pc          = r_if_id.pc;
    assign if_id_pc_plus1    = r_if_id.pc_plus1;
    assign if_id_valid       = r_if_id.valid;
    assign if_id_fault       = r_if_id.fault;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a synchronous
// 256-word memory model and a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        if_id_fault;

    logic [31:0] mem [0:255];

    // Behavioural model state.
    logic [31:0] m_pc, m_fpc, m_instr, m_ipc, m_ipc1, m_addr;
    logic        m_fvalid, m_valid, m_fault, m_known;
    int          checks;
    int          errors;

    logic [97:0] got_v;
    logic [97:0] exp_v;

    assign got_v = {if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1,
                    (m_known ? if_id_instruction : 32'd0)};
    assign exp_v = {m_valid, m_fault, m_ipc, m_ipc1,
                    (m_known ? m_instr : 32'd0)};

    instruction_fetch_unit #(.RESET_PC(32'd0), .IMEM_DEPTH(256)) dut (
        .clock            (clock),
        .reset            (reset),
        .stall            (stall),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .if_id_instruction(if_id_instruction),
        .if_id_pc         (if_id_pc),
        .if_id_pc_plus1   (if_id_pc_plus1),
        .if_id_valid      (if_id_valid),
        .if_id_fault      (if_id_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read memory; out-of-range reads return garbage.
    always @(posedge clock) begin
        if (imem_address < 32'd256) imem_instruction <= mem[imem_address[7:0]];
        else                        imem_instruction <= $urandom;
    end

    // Apply inputs away from the clock edge and predict the memory address.
    task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] t);
        @(negedge clock);
        reset = r; stall = s; redirect_valid = rv; redirect_target = t;
        if (r)       m_addr = 32'd0;
        else if (rv) m_addr = t;
        else if (s)  m_addr = m_fpc;
        else         m_addr = m_pc;
        #1;
    endtask

    // Advance one edge and update the model from the applied inputs.
    task automatic tick();
        logic in_rng;
        @(posedge clock);
        if (reset) begin
            m_pc = 32'd0; m_fpc = 32'd0; m_fvalid = 1'b0;
            m_instr = 32'd0; m_ipc = 32'd0; m_ipc1 = 32'd0;
            m_valid = 1'b0; m_fault = 1'b0; m_known = 1'b1;
        end else if (redirect_valid) begin
            m_instr = 32'd0; m_valid = 1'b0; m_fault = 1'b0; m_known = 1'b1;
            m_fpc = redirect_target; m_fvalid = 1'b1; m_pc = redirect_target + 32'd1;
        end else if (!stall) begin
            in_rng  = (m_fpc < 32'd256);
            m_known = m_fvalid && in_rng;
            m_instr = in_rng ? mem[m_fpc[7:0]] : 32'd0;
            m_ipc   = m_fpc;
            m_ipc1  = m_fpc + 32'd1;
            m_valid = m_fvalid && in_rng;
            m_fault = m_fvalid && !in_rng;
            m_fpc   = m_pc;
            m_fvalid = 1'b1;
            m_pc    = m_pc + 32'd1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b1, 32'd77);
            checks++;
            if (imem_address !== 32'd0) begin
                errors++;
                $display("FAIL reset_addr: got %h expected %h", imem_address, 32'd0);
            end
            tick();
        end
        checks++;
        if ({if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1, if_id_instruction} !== 98'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b f=%b pc=%h pc1=%h ins=%h expected all zero",
                     if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1, if_id_instruction);
        end
    endtask

    task automatic test_free_run();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            checks++;
            if (imem_address !== 32'(k - 1)) begin
                errors++;
                $display("FAIL free_run_addr: got %h expected %h", imem_address, 32'(k - 1));
            end
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL free_run_ifid edge %0d: got %h expected %h", k, got_v, exp_v);
            end
            if (k >= 2) begin
                checks++;
                if (if_id_valid !== 1'b1 || if_id_pc !== 32'(k - 2) ||
                    if_id_pc_plus1 !== 32'(k - 1) || if_id_instruction !== mem[k - 2]) begin
                    errors++;
                    $display("FAIL free_run_stream edge %0d: got v=%b pc=%h pc1=%h ins=%h expected pc=%h ins=%h",
                             k, if_id_valid, if_id_pc, if_id_pc_plus1, if_id_instruction, 32'(k - 2), mem[k - 2]);
                end
            end
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 32'd0); tick();
        drive(1'b1, 1'b0, 1'b0, 32'd0); tick();
        for (int i = 0; i < 3; i++) begin drive(1'b0, 1'b0, 1'b0, 32'd0); tick(); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            checks++;
            if (imem_address !== 32'd2) begin
                errors++;
                $display("FAIL stall_addr: got %h expected %h", imem_address, 32'd2);
            end
            tick();
            checks++;
            if (got_v !== exp_v || if_id_pc !== 32'd1 || if_id_instruction !== mem[1]) begin
                errors++;
                $display("FAIL stall_hold: got %h expected %h", got_v, exp_v);
            end
        end
        for (int k = 2; k <= 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            tick();
            checks++;
            if (got_v !== exp_v || if_id_valid !== 1'b1 || if_id_pc !== 32'(k) ||
                if_id_instruction !== mem[k]) begin
                errors++;
                $display("FAIL stall_release pc %0d: got %h expected %h", k, got_v, exp_v);
            end
        end
    endtask

    task automatic test_redirect();
        drive(1'b0, 1'b0, 1'b1, 32'd24);
        checks++;
        if (imem_address !== 32'd24) begin
            errors++;
            $display("FAIL redirect_addr: got %h expected %h", imem_address, 32'd24);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_fault !== 1'b0 || if_id_instruction !== 32'd0 ||
            if_id_pc !== 32'd3 || if_id_pc_plus1 !== 32'd4) begin
            errors++;
            $display("FAIL redirect_flush: got v=%b f=%b ins=%h pc=%h pc1=%h expected v=0 ins=0 pc=3 pc1=4",
                     if_id_valid, if_id_fault, if_id_instruction, if_id_pc, if_id_pc_plus1);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        checks++;
        if (got_v !== exp_v || if_id_valid !== 1'b1 || if_id_pc !== 32'd24 ||
            if_id_instruction !== mem[24]) begin
            errors++;
            $display("FAIL redirect_target_word: got %h expected %h", got_v, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_address !== 32'd26) begin
            errors++;
            $display("FAIL redirect_pc_advance: got %h expected %h", imem_address, 32'd26);
        end
        tick();
    endtask

    task automatic test_redirect_stall();
        drive(1'b0, 1'b1, 1'b1, 32'd29);
        checks++;
        if (imem_address !== 32'd29) begin
            errors++;
            $display("FAIL redir_stall_addr: got %h expected %h", imem_address, 32'd29);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'd0);
            checks++;
            if (imem_address !== 32'd29 || if_id_valid !== 1'b0) begin
                errors++;
                $display("FAIL redir_stall_hold: got addr=%h v=%b expected addr=%h v=0",
                         imem_address, if_id_valid, 32'd29);
            end
            tick();
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        checks++;
        if (got_v !== exp_v || if_id_valid !== 1'b1 || if_id_pc !== 32'd29 ||
            if_id_instruction !== mem[29]) begin
            errors++;
            $display("FAIL redir_stall_deliver: got %h expected %h", got_v, exp_v);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        checks++;
        if (if_id_pc !== 32'd30 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_stall_next: got pc=%h v=%b expected pc=%h v=1", if_id_pc, if_id_valid, 32'd30);
        end
    endtask

    task automatic test_boundary();
        drive(1'b0, 1'b0, 1'b1, 32'd255); tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);   tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_fault !== 1'b0 || if_id_pc !== 32'd255 ||
            if_id_instruction !== mem[255]) begin
            errors++;
            $display("FAIL boundary_last: got v=%b f=%b pc=%h ins=%h expected v=1 f=0 pc=ff ins=%h",
                     if_id_valid, if_id_fault, if_id_pc, if_id_instruction, mem[255]);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0); tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_fault !== 1'b1 || if_id_pc !== 32'd256 ||
            if_id_pc_plus1 !== 32'd257) begin
            errors++;
            $display("FAIL boundary_fault: got v=%b f=%b pc=%h pc1=%h expected v=0 f=1 pc=100 pc1=101",
                     if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1);
        end
        drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF); tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_address !== 32'd0) begin
            errors++;
            $display("FAIL wrap_addr: got %h expected %h", imem_address, 32'd0);
        end
        tick();
        checks++;
        if (if_id_fault !== 1'b1 || if_id_valid !== 1'b0 || if_id_pc !== 32'hFFFF_FFFF ||
            if_id_pc_plus1 !== 32'd0) begin
            errors++;
            $display("FAIL wrap_ifid: got v=%b f=%b pc=%h pc1=%h expected v=0 f=1 pc=ffffffff pc1=0",
                     if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0); tick();
        checks++;
        if (got_v !== exp_v || if_id_valid !== 1'b1 || if_id_pc !== 32'd0 ||
            if_id_instruction !== mem[0]) begin
            errors++;
            $display("FAIL wrap_resume: got %h expected %h", got_v, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b0, 1'b0, 32'd0); tick(); end
        drive(1'b1, 1'b1, 1'b1, 32'd5);
        checks++;
        if (imem_address !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_addr: got %h expected %h", imem_address, 32'd0);
        end
        tick();
        checks++;
        if ({if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1, if_id_instruction} !== 98'd0) begin
            errors++;
            $display("FAIL reset_mid_state: got v=%b f=%b pc=%h pc1=%h ins=%h expected all zero",
                     if_id_valid, if_id_fault, if_id_pc, if_id_pc_plus1, if_id_instruction);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0); tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0); tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'd0 || if_id_instruction !== mem[0]) begin
            errors++;
            $display("FAIL reset_mid_restart: got v=%b pc=%h ins=%h expected v=1 pc=0 ins=%h",
                     if_id_valid, if_id_pc, if_id_instruction, mem[0]);
        end
    endtask

    task automatic test_random();
        logic        r, s, rv;
        logic [31:0] t;
        for (int c = 0; c < 400; c++) begin
            r  = ($urandom_range(99) < 2);
            s  = ($urandom_range(99) < 25);
            rv = ($urandom_range(99) < 10);
            t  = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15)))
                                          : 32'($urandom_range(300));
            drive(r, s, rv, t);
            checks++;
            if (imem_address !== m_addr) begin
                errors++;
                $display("FAIL random_addr cycle %0d: got %h expected %h", c, imem_address, m_addr);
            end
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_ifid cycle %0d: got %h expected %h", c, got_v, exp_v);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
        m_pc = 32'd0; m_fpc = 32'd0; m_fvalid = 1'b0; m_instr = 32'd0;
        m_ipc = 32'd0; m_ipc1 = 32'd0; m_valid = 1'b0; m_fault = 1'b0;
        m_known = 1'b1; m_addr = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = make_instr(OP_ADDI, 5'd1, 5'd2, 16'd10);
        mem[1] = make_instr(OP_ADDI, 5'd2, 5'd3, 16'd20);
        mem[2] = make_instr(OP_AND,  5'd3, 5'd1, 16'h1000);
        mem[3] = make_instr(OP_ADD,  5'd4, 5'd1, 16'h1000);
        mem[4] = make_instr(OP_SUB,  5'd5, 5'd2, 16'h0800);

        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_boundary();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
